// File: rtl/tdpu_dot_accum_pkg.sv
// Shared types for the ternary dot-product accumulator.
// weight_t: 2-bit ternary weight code. W_ZERO, W_POS and W_NEG are legal codes.
// The remaining code, 2'b11, is illegal and the datapath treats it as zero.
package tdpu_dot_accum_pkg;

  typedef logic [1:0] weight_t;

  localparam weight_t W_ZERO = 2'b00;
  localparam weight_t W_POS  = 2'b01;
  localparam weight_t W_NEG  = 2'b10;

endpackage

// File: rtl/tdpu_dot_accum_if.sv
// Bus bundle for tdpu_dot_accum: weight-bank write port, input beat
// channel (i_valid/o_ready) and result channel (o_valid/i_ready).
// Modports: slave (the engine) and master (the driver of beats and weights).
interface tdpu_dot_accum_if #(
  parameter int unsigned LEN         = 32,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned WBANK_DEPTH = 8
);
  import tdpu_dot_accum_pkg::*;

  localparam int unsigned AW = $clog2(WBANK_DEPTH);

  logic                                i_wr_weight_en;
  logic [AW-1:0]                       i_wr_weight_addr;
  weight_t [LEN-1:0]                   i_wr_weight;
  logic                                i_valid;
  logic                                o_ready;
  logic [LEN-1:0][DATA_WIDTH-1:0]      i_data;
  logic [AW-1:0]                       i_row;
  logic                                i_last;
  logic                                o_valid;
  logic                                i_ready;
  logic signed [ACC_WIDTH-1:0]         o_result;
  logic                                o_sat;

  modport slave (
    input  i_wr_weight_en, i_wr_weight_addr, i_wr_weight,
    input  i_valid, i_data, i_row, i_last, i_ready,
    output o_ready, o_valid, o_result, o_sat
  );

  modport master (
    output i_wr_weight_en, i_wr_weight_addr, i_wr_weight,
    output i_valid, i_data, i_row, i_last, i_ready,
    input  o_ready, o_valid, o_result, o_sat
  );

endinterface

// File: rtl/tdpu_dot_accum.sv
// Ternary-weight dot-product engine with multi-beat accumulation.
// Each accepted beat multiplies i_data by one row of a local ternary weight
// bank, reduces the products through a registered adder tree, and adds the
// result into a saturating accumulator. The group total is presented on
// o_result/o_sat when the beat flagged i_last reaches the accumulator.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset
//   bus   - tdpu_dot_accum_if.slave, carrying:
//           - the weight write port;
//           - the beat input channel (i_valid/o_ready);
//           - the result channel (o_valid/i_ready).
// Macro TDPU_DOT_ACCUM_RELU_EN applies a ReLU to the final result.
// o_sat and the intermediate accumulation are not affected by it.
module tdpu_dot_accum
  import tdpu_dot_accum_pkg::*;
#(
  parameter int unsigned LEN         = 32,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned WBANK_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  tdpu_dot_accum_if.slave    bus
);

  localparam int unsigned TD   = $clog2(LEN);
  localparam int unsigned PW   = DATA_WIDTH + 1;
  localparam int unsigned TW   = DATA_WIDTH + 1 + TD;
  localparam int unsigned SW   = ACC_WIDTH + 1;
  localparam int unsigned HALF = LEN / 2;

  logic                        stall;
  logic                        accept;
  weight_t [LEN-1:0]           bank [WBANK_DEPTH];
  weight_t [LEN-1:0]           rd_row;
  logic signed [PW-1:0]        prod_c [LEN];
  logic signed [PW-1:0]        prod_q [LEN];
  logic                        p_valid_q;
  logic                        p_last_q;
  logic signed [TW-1:0]        tree_q [TD][HALF];
  logic [TD-1:0]               t_valid_q;
  logic [TD-1:0]               t_last_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic                        gsat_q;
  logic signed [SW-1:0]        sum_c;
  logic                        ovf_c;
  logic signed [ACC_WIDTH-1:0] clamp_c;
  logic signed [ACC_WIDTH-1:0] res_c;

  // A held result freezes the whole pipeline.
  assign stall       = bus.o_valid && !bus.i_ready;
  assign bus.o_ready = !stall;
  assign accept      = bus.i_valid && !stall;

  // Weight bank. The write port is independent of stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < WBANK_DEPTH; r++) bank[r] <= {LEN{W_ZERO}};
    end else if (bus.i_wr_weight_en) begin
      bank[bus.i_wr_weight_addr] <= bus.i_wr_weight;
    end
  end

  // The read sees the pre-write contents: a same-cycle write applies to later beats.
  assign rd_row = bank[bus.i_row];

  // Ternary multiply. One extra bit keeps the negation of the most negative value exact.
  always_comb begin
    for (int unsigned e = 0; e < LEN; e++) begin
      prod_c[e] = '0;
      case (rd_row[e])
        W_POS:   prod_c[e] = PW'($signed(bus.i_data[e]));
        W_NEG:   prod_c[e] = -PW'($signed(bus.i_data[e]));
        default: prod_c[e] = '0;
      endcase
    end
  end

  // Product stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_valid_q <= 1'b0;
      p_last_q  <= 1'b0;
    end else if (!stall) begin
      p_valid_q <= accept;
      p_last_q  <= bus.i_last;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) prod_q <= prod_c;
  end

  // Adder tree.
  // Each level is held in a TW-wide slot but carries only its nominal level width.
  // Slots past a level's node count are tied to zero.
  for (genvar n = 0; n < TD; n++) begin : g_lvl
    localparam int unsigned LW = DATA_WIDTH + 2 + n;
    for (genvar k = 0; k < HALF; k++) begin : g_node
      if (k < (LEN >> (n + 1))) begin : g_sum
        if (n == 0) begin : g_leaf
          always_ff @(posedge clk) begin
            if (!stall) tree_q[0][k] <= TW'(LW'(prod_q[2*k]) + LW'(prod_q[2*k+1]));
          end
        end else begin : g_inner
          always_ff @(posedge clk) begin
            if (!stall) tree_q[n][k] <= TW'(LW'(tree_q[n-1][2*k] + tree_q[n-1][2*k+1]));
          end
        end
      end else begin : g_pad
        always_ff @(posedge clk) begin
          tree_q[n][k] <= '0;
        end
      end
    end
  end

  // Valid and last bits travel alongside the tree levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_valid_q <= '0;
      t_last_q  <= '0;
    end else if (!stall) begin
      t_valid_q[0] <= p_valid_q;
      t_last_q[0]  <= p_last_q;
      for (int unsigned i = 1; i < TD; i++) begin
        t_valid_q[i] <= t_valid_q[i-1];
        t_last_q[i]  <= t_last_q[i-1];
      end
    end
  end

  // Saturating add. Overflow shows up as disagreeing top two bits of the widened sum.
  always_comb begin
    sum_c   = SW'(acc_q) + SW'(tree_q[TD-1][0]);
    ovf_c   = sum_c[ACC_WIDTH] ^ sum_c[ACC_WIDTH-1];
    clamp_c = sum_c[ACC_WIDTH-1:0];
    if (ovf_c) clamp_c = {sum_c[ACC_WIDTH], {(ACC_WIDTH-1){~sum_c[ACC_WIDTH]}}};
    res_c   = clamp_c;
`ifdef TDPU_DOT_ACCUM_RELU_EN
    if (clamp_c[ACC_WIDTH-1]) res_c = '0;
`endif
  end

  // Accumulator and output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q        <= '0;
      gsat_q       <= 1'b0;
      bus.o_valid  <= 1'b0;
      bus.o_result <= '0;
      bus.o_sat    <= 1'b0;
    end else if (!stall) begin
      if (t_valid_q[TD-1] && t_last_q[TD-1]) begin
        bus.o_result <= res_c;
        bus.o_sat    <= gsat_q | ovf_c;
        bus.o_valid  <= 1'b1;
        acc_q        <= '0;
        gsat_q       <= 1'b0;
      end else begin
        bus.o_valid <= 1'b0;
        if (t_valid_q[TD-1]) begin
          acc_q  <= clamp_c;
          gsat_q <= gsat_q | ovf_c;
        end
      end
    end
  end

endmodule
